// File: rtl/car_light_decoder.sv
// car_light_decoder
//
// Independent receive-side monitor for the tail-light sequencer. On every
// enabled clock edge it classifies the step from the previously sampled lamp
// pattern to the current one and tracks whether the car is turning left,
// turning right, flashing hazards, idle, or producing an illegal sequence.
// It also counts completed flash cycles per mode.
//
// Parameters:
//   QUIET_CYCLES  consecutive quiet (000/000 -> 000/000) steps needed to leave
//                 FAULT, 1..15
// Ports:
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset (dominates sample_en)
//   sample_en     1 = sample the lamp buses this edge, 0 = hold every register
//   light_left    left lamp bus, bit0 inner .. bit2 outer
//   light_right   right lamp bus, same bit order
//   left_on       registered: decoder in L_SEQ
//   right_on      registered: decoder in R_SEQ
//   hazard_on     registered: decoder in HAZ
//   fault         registered: decoder in FAULT
//   left_count    completed left cycles (wraps)
//   right_count   completed right cycles (wraps)
//   hazard_count  completed hazard cycles (wraps)
//
// Handshake: there is no valid/ready pair; sample_en acts as a qualifier only.
// A sample is consumed on every rising edge where sample_en is 1, and nothing
// changes on edges where it is 0. The state is visible through the four
// registered flags (all low means IDLE).

module car_light_decoder #(
    parameter int QUIET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_en,
    input  logic [2:0] light_left,
    input  logic [2:0] light_right,
    output logic       left_on,
    output logic       right_on,
    output logic       hazard_on,
    output logic       fault,
    output logic [7:0] left_count,
    output logic [7:0] right_count,
    output logic [7:0] hazard_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L_SEQ,
        S_R_SEQ,
        S_HAZ,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_QUIET,
        C_LSTEP,
        C_LSTOP,
        C_RSTEP,
        C_RSTOP,
        C_HSTEP,
        C_ILLEGAL
    } class_t;

    localparam logic [3:0] QUIET_LIMIT = 4'(QUIET_CYCLES);

    state_t     state, state_next;
    class_t     step_class;
    logic [2:0] prev_l, prev_r;
    logic [3:0] quiet_cnt, quiet_next, quiet_inc;
    logic       inc_left, inc_right, inc_hazard;

    // Legal single-side turn progression: 000 -> 001 -> 011 -> 111 -> 000.
    function automatic logic turn_step(input logic [2:0] p, input logic [2:0] c);
        case ({p, c})
            6'b000_001, 6'b001_011, 6'b011_111, 6'b111_000: turn_step = 1'b1;
            default:                                        turn_step = 1'b0;
        endcase
    endfunction

    // Turn abandoned before reaching the full 111 pattern.
    function automatic logic turn_stop(input logic [2:0] p, input logic [2:0] c);
        case ({p, c})
            6'b001_000, 6'b011_000: turn_stop = 1'b1;
            default:                turn_stop = 1'b0;
        endcase
    endfunction

    logic l_dark, r_dark;
    assign l_dark = (prev_l == 3'b000) && (light_left == 3'b000);
    assign r_dark = (prev_r == 3'b000) && (light_right == 3'b000);

    always_comb begin
        step_class = C_ILLEGAL;
        if (l_dark && r_dark)
            step_class = C_QUIET;
        else if (r_dark && turn_step(prev_l, light_left))
            step_class = C_LSTEP;
        else if (r_dark && turn_stop(prev_l, light_left))
            step_class = C_LSTOP;
        else if (l_dark && turn_step(prev_r, light_right))
            step_class = C_RSTEP;
        else if (l_dark && turn_stop(prev_r, light_right))
            step_class = C_RSTOP;
        else if (({prev_l, prev_r} == 6'b000_000 && {light_left, light_right} == 6'b111_111) ||
                 ({prev_l, prev_r} == 6'b111_111 && {light_left, light_right} == 6'b000_000))
            step_class = C_HSTEP;
    end

    assign quiet_inc = quiet_cnt + 4'd1;

    always_comb begin
        state_next = state;
        quiet_next = 4'd0;
        inc_left   = 1'b0;
        inc_right  = 1'b0;
        inc_hazard = 1'b0;
        if (state == S_FAULT) begin
            // Only an unbroken run of quiet steps recovers; anything else,
            // even a legal step, restarts the run.
            if (step_class == C_QUIET) begin
                if (quiet_inc == QUIET_LIMIT) begin
                    state_next = S_IDLE;
                end else begin
                    quiet_next = quiet_inc;
                end
            end
        end else begin
            case (step_class)
                C_QUIET, C_LSTOP, C_RSTOP: state_next = S_IDLE;
                C_LSTEP: begin
                    state_next = S_L_SEQ;
                    inc_left   = (prev_l == 3'b111);
                end
                C_RSTEP: begin
                    state_next = S_R_SEQ;
                    inc_right  = (prev_r == 3'b111);
                end
                C_HSTEP: begin
                    state_next = S_HAZ;
                    inc_hazard = (prev_l == 3'b111);
                end
                default: state_next = S_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            prev_l       <= 3'b000;
            prev_r       <= 3'b000;
            quiet_cnt    <= 4'd0;
            left_on      <= 1'b0;
            right_on     <= 1'b0;
            hazard_on    <= 1'b0;
            fault        <= 1'b0;
            left_count   <= 8'h00;
            right_count  <= 8'h00;
            hazard_count <= 8'h00;
        end else if (sample_en) begin
            state        <= state_next;
            prev_l       <= light_left;
            prev_r       <= light_right;
            quiet_cnt    <= quiet_next;
            left_on      <= (state_next == S_L_SEQ);
            right_on     <= (state_next == S_R_SEQ);
            hazard_on    <= (state_next == S_HAZ);
            fault        <= (state_next == S_FAULT);
            left_count   <= left_count + 8'(inc_left);
            right_count  <= right_count + 8'(inc_right);
            hazard_count <= hazard_count + 8'(inc_hazard);
        end
    end

endmodule

// File: tb/tb_car_light_decoder.sv
// Testbench for car_light_decoder: a table of directed vectors plus
// hand-written multi-cycle sequences (wrap-around, mid-sequence reset).
// Expected outputs are pushed to a queue when a vector is driven and popped
// and compared one time unit after the sampling edge.

module tb_car_light_decoder;

    localparam int W = 28;  // {left_on, right_on, hazard_on, fault, lc, rc, hc}

    localparam logic [3:0] F_IDLE = 4'b0000;
    localparam logic [3:0] F_L    = 4'b1000;
    localparam logic [3:0] F_R    = 4'b0100;
    localparam logic [3:0] F_H    = 4'b0010;
    localparam logic [3:0] F_F    = 4'b0001;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_en = 1'b0;
    logic [2:0] light_left = 3'b000;
    logic [2:0] light_right = 3'b000;
    logic       left_on, right_on, hazard_on, fault;
    logic [7:0] left_count, right_count, hazard_count;

    car_light_decoder #(.QUIET_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_en    (sample_en),
        .light_left   (light_left),
        .light_right  (light_right),
        .left_on      (left_on),
        .right_on     (right_on),
        .hazard_on    (hazard_on),
        .fault        (fault),
        .left_count   (left_count),
        .right_count  (right_count),
        .hazard_count (hazard_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    typedef struct {
        logic         en;
        logic [2:0]   l;
        logic [2:0]   r;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [W-1:0] mk(input logic [3:0] flags, input logic [7:0] lc,
                                        input logic [7:0] rc, input logic [7:0] hc);
        return {flags, lc, rc, hc};
    endfunction

    task automatic add(input logic en, input logic [2:0] l, input logic [2:0] r,
                       input logic [3:0] flags, input logic [7:0] lc, input logic [7:0] rc,
                       input logic [7:0] hc, input string name);
        vec_t v;
        v.en = en; v.l = l; v.r = r; v.exp = mk(flags, lc, rc, hc); v.name = name;
        tbl.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst_n, input logic en, input logic [2:0] l,
                        input logic [2:0] r, input logic [W-1:0] exp, input string name);
        logic [W-1:0] e;
        logic [W-1:0] act;
        string        n;
        @(negedge clk);
        reset_n     = rst_n;
        sample_en   = en;
        light_left  = l;
        light_right = r;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        act = {left_on, right_on, hazard_on, fault, left_count, right_count, hazard_count};
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got LRHF=%b counts=%h/%h/%h, expected LRHF=%b counts=%h/%h/%h",
                     n, act[27:24], act[23:16], act[15:8], act[7:0],
                     e[27:24], e[23:16], e[15:8], e[7:0]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] lc;

        // Left turn, one full cycle, then abort on the next
        add(1, 3'b001, 3'b000, F_L,    8'd0, 8'd0, 8'd0, "left_001");
        add(1, 3'b011, 3'b000, F_L,    8'd0, 8'd0, 8'd0, "left_011");
        add(1, 3'b111, 3'b000, F_L,    8'd0, 8'd0, 8'd0, "left_111");
        add(1, 3'b000, 3'b000, F_L,    8'd1, 8'd0, 8'd0, "left_wrap_step");
        add(1, 3'b001, 3'b000, F_L,    8'd1, 8'd0, 8'd0, "left_001_again");
        add(1, 3'b000, 3'b000, F_IDLE, 8'd1, 8'd0, 8'd0, "left_stop");
        // Hazard
        add(1, 3'b111, 3'b111, F_H,    8'd1, 8'd0, 8'd0, "haz_on1");
        add(1, 3'b000, 3'b000, F_H,    8'd1, 8'd0, 8'd1, "haz_off1");
        add(1, 3'b111, 3'b111, F_H,    8'd1, 8'd0, 8'd1, "haz_on2");
        add(1, 3'b000, 3'b000, F_H,    8'd1, 8'd0, 8'd2, "haz_off2");
        add(1, 3'b000, 3'b000, F_IDLE, 8'd1, 8'd0, 8'd2, "haz_quiet_idle");
        // Right turn aborted
        add(1, 3'b000, 3'b001, F_R,    8'd1, 8'd0, 8'd2, "right_001");
        add(1, 3'b000, 3'b011, F_R,    8'd1, 8'd0, 8'd2, "right_011");
        add(1, 3'b000, 3'b000, F_IDLE, 8'd1, 8'd0, 8'd2, "right_stop");
        // Full right cycle, then direct switch to left
        add(1, 3'b000, 3'b001, F_R,    8'd1, 8'd0, 8'd2, "right2_001");
        add(1, 3'b000, 3'b011, F_R,    8'd1, 8'd0, 8'd2, "right2_011");
        add(1, 3'b000, 3'b111, F_R,    8'd1, 8'd0, 8'd2, "right2_111");
        add(1, 3'b000, 3'b000, F_R,    8'd1, 8'd1, 8'd2, "right2_wrap_step");
        add(1, 3'b001, 3'b000, F_L,    8'd1, 8'd1, 8'd2, "side_switch");
        // Illegal input, fault recovery with a restarted quiet run
        add(1, 3'b001, 3'b001, F_F,    8'd1, 8'd1, 8'd2, "illegal_001_001");
        add(1, 3'b111, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_illegal");
        add(1, 3'b000, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_no_count");
        add(1, 3'b000, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_quiet1");
        add(1, 3'b000, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_quiet2");
        add(1, 3'b001, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_restart");
        add(1, 3'b000, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_stop_not_quiet");
        add(1, 3'b000, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_requiet1");
        add(1, 3'b000, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_requiet2");
        add(1, 3'b000, 3'b000, F_F,    8'd1, 8'd1, 8'd2, "fault_requiet3");
        add(1, 3'b000, 3'b000, F_IDLE, 8'd1, 8'd1, 8'd2, "fault_requiet4_exit");
        // sample_en gaps: compare against the last enabled sample
        add(1, 3'b001, 3'b000, F_L,    8'd1, 8'd1, 8'd2, "en_001");
        add(0, 3'b011, 3'b000, F_L,    8'd1, 8'd1, 8'd2, "hold_011");
        add(0, 3'b111, 3'b000, F_L,    8'd1, 8'd1, 8'd2, "hold_111");
        add(1, 3'b011, 3'b000, F_L,    8'd1, 8'd1, 8'd2, "en_011_after_gap");
        add(1, 3'b111, 3'b000, F_L,    8'd1, 8'd1, 8'd2, "en_111");
        add(1, 3'b000, 3'b000, F_L,    8'd2, 8'd1, 8'd2, "en_wrap_step");

        // Reset with junk inputs and sample enabled: reset wins
        step(0, 1, 3'b010, 3'b101, mk(F_IDLE, 8'd0, 8'd0, 8'd0), "reset");
        step(0, 1, 3'b110, 3'b111, mk(F_IDLE, 8'd0, 8'd0, 8'd0), "reset_hold");

        for (int i = 0; i < tbl.size(); i++)
            step(1, tbl[i].en, tbl[i].l, tbl[i].r, tbl[i].exp, tbl[i].name);

        // Wrap test: 256 full left cycles from a fresh reset
        step(0, 0, 3'b000, 3'b000, mk(F_IDLE, 8'd0, 8'd0, 8'd0), "wrap_reset");
        lc = 8'd0;
        for (int i = 0; i < 256; i++) begin
            step(1, 1, 3'b001, 3'b000, mk(F_L, lc, 8'd0, 8'd0), "wrap_001");
            step(1, 1, 3'b011, 3'b000, mk(F_L, lc, 8'd0, 8'd0), "wrap_011");
            step(1, 1, 3'b111, 3'b000, mk(F_L, lc, 8'd0, 8'd0), "wrap_111");
            lc = lc + 8'd1;
            step(1, 1, 3'b000, 3'b000, mk(F_L, lc, 8'd0, 8'd0), "wrap_000");
        end
        step(1, 1, 3'b000, 3'b000, mk(F_IDLE, 8'h00, 8'd0, 8'd0), "wrap_256_is_zero");

        // Reset mid-sequence (with sample_en low), then resume at 011
        step(1, 1, 3'b001, 3'b000, mk(F_L, 8'd0, 8'd0, 8'd0), "mid_001");
        step(1, 1, 3'b011, 3'b000, mk(F_L, 8'd0, 8'd0, 8'd0), "mid_011");
        step(0, 0, 3'b011, 3'b000, mk(F_IDLE, 8'd0, 8'd0, 8'd0), "mid_reset");
        step(1, 1, 3'b011, 3'b000, mk(F_F, 8'd0, 8'd0, 8'd0), "post_reset_011_fault");

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/car_light_decoder.md
# car_light_decoder

Receive-side checker for the tail-light sequencer. Watches the two 3-bit lamp buses (`light_left`, `light_right`) driven by `car_light` and decodes, one sample per enabled clock, whether the car is showing a left turn, right turn, hazard flash, idle, or an illegal lamp sequence. It sits beside `car_light` in the dashboard/test harness as an independent protocol monitor. It also counts completed flash cycles per mode.

## Interface
- `QUIET_CYCLES`, default 4: consecutive quiet samples required to leave FAULT (range 1–15).
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset_n`  input  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `sample_en`  input  1: when 1, the current lamp buses are sampled this edge; when 0, all registers hold.
- `light_left`  input  3: left lamp bus, bit0 = inner lamp, bit2 = outer lamp.
- `light_right`  input  3: right lamp bus, same bit order.
- `left_on`  output  1: decoder is in L_SEQ.
- `right_on`  output  1: decoder is in R_SEQ.
- `hazard_on`  output  1: decoder is in HAZ.
- `fault`  output  1: decoder is in FAULT.
- `left_count`  output  8: completed left cycles, wraps 255→0.
- `right_count`  output  8: completed right cycles, wraps 255→0.
- `hazard_count`  output  8: completed hazard cycles (111/111→000/000 steps), wraps.

## Operation
- Internal registers:
  - `prev_l`, `prev_r` (3b each): the last sampled lamp values.
  - state: IDLE, L_SEQ, R_SEQ, HAZ or FAULT.
  - `quiet_cnt` (4b).
- Each enabled edge classifies the transition from (`prev_l`,`prev_r`) to (`light_left`,`light_right`) as exactly one of the following classes:
  - QUIET: 000/000 → 000/000.
  - LSTEP: right 000→000, and left follows one of the legal turn steps 000→001, 001→011, 011→111, 111→000.
  - LSTOP: right 000→000, and left goes 001→000 or 011→000 (turn aborted mid-sequence).
  - RSTEP and RSTOP: the mirror of LSTEP and LSTOP with the sides swapped.
  - HSTEP: 000/000 → 111/111, or 111/111 → 000/000.
  - ILLEGAL: any other transition, including any input containing a non-pattern value such as 010, 101 or 110.
- Next state from a non-FAULT state:
  - QUIET, LSTOP or RSTOP → IDLE.
  - LSTEP → L_SEQ.
  - RSTEP → R_SEQ.
  - HSTEP → HAZ.
  - ILLEGAL → FAULT.
  - A direct side switch is therefore legal: in R_SEQ with prev 000/000, an input of 001/000 goes to L_SEQ.
- FAULT state:
  - QUIET increments `quiet_cnt`. When the incremented value equals `QUIET_CYCLES`, the next state is IDLE and `quiet_cnt` clears.
  - Any other class clears `quiet_cnt` and stays in FAULT.
  - `quiet_cnt` is 0 whenever the decoder is not in FAULT.
- Counters:
  - `left_count` increments on an LSTEP of 111→000.
  - `right_count` increments on an RSTEP of 111→000.
  - `hazard_count` increments on an HSTEP of 111/111→000/000.
  - Counters increment only when the current state is not FAULT and the class is legal.
  - Counters never saturate; they wrap.
- `prev_l` and `prev_r` load the inputs on every enabled edge, in all states.

## Timing
- All outputs are registered.
- Reset values: `left_on`, `right_on`, `hazard_on` and `fault` = 0; all counts = 0x00; state IDLE; `prev_l` = `prev_r` = 000; `quiet_cnt` = 0.
- Latency: a transition whose current sample is taken at edge N is reflected on the state flags and counts immediately after edge N (one cycle from the input change).
- `sample_en` = 0: no register changes. The next enabled edge compares against the last enabled sample, not against the cycle before.
- Reset dominates `sample_en`. A reset mid-sequence returns the decoder to IDLE with prev 000/000. The first post-reset sample of 011/000 is therefore ILLEGAL → FAULT.
- Exactly one of the four state flags is high, except in IDLE, where all four are low.

## Test plan
- Reset, then left 000→001→011→111→000→001 on consecutive enabled edges:
  - `left_on` = 1 after the first step.
  - `left_count` = 1 after the 111→000 edge.
  - `fault` = 0 throughout.
- Hazard: 111/111, 000/000, 111/111, 000/000:
  - `hazard_on` = 1 throughout.
  - `hazard_count` = 2.
  - Then 000/000 → IDLE, all flags 0.
- Right 001→011 then 000, with left held at 000:
  - RSTOP → IDLE.
  - `right_count` stays 0, `fault` = 0.
- Left at 001, then an input of 001/001:
  - `fault` = 1.
  - With `QUIET_CYCLES` = 4, `fault` drops after the 4th consecutive 000/000 sample.
  - A legal step inserted after the 2nd quiet sample restarts the quiet count.
- `sample_en` toggled 1,0,0,1 while left steps 000→001 (enabled), 011 and 111 driven while disabled, then 011 (enabled):
  - The decoded step is 001→011 (legal).
  - `left_on` = 1 and no fault.
- Wrap test:
  - 256 complete left cycles → `left_count` = 0x00.
  - Assert `reset_n` = 0 mid-cycle at left = 011, then release with left = 011 → `fault` = 1.
